// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage with optional even parity and done pulse
//
// Purpose:
//    Captures a parallel word on a V/RDY handshake and shifts it out one bit
//    per enabled clock on SO/SV. An even-parity bit can be appended, and DN
//    pulses for one cycle once the frame has been sent. Every output is a
//    flop, so there is no combinational path from any input to any output.
//
// Parameters:
//    WIDTH      data word width, 2..16
//    MSB_FIRST  1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first
//    PARITY_EN  1 = append one even-parity bit after the data bits
//
// Ports:
//    C    in   clock, rising edge
//    R    in   asynchronous active-low reset
//    A    in   parallel data word
//    V    in   word valid
//    RDY  out  ready, high only while idle
//    E    in   shift enable, 0 stalls the frame
//    SO   out  serial data
//    SV   out  serial bit valid
//    BZ   out  busy, from acceptance until the done cycle has passed
//    DN   out  one-cycle done pulse after the last frame bit

module piso_serializer #(
   parameter int WIDTH     = 4,
   parameter int MSB_FIRST = 1,
   parameter int PARITY_EN = 1
) (
   input  logic             C,
   input  logic             R,
   input  logic [WIDTH-1:0] A,
   input  logic             V,
   output logic             RDY,
   input  logic             E,
   output logic             SO,
   output logic             SV,
   output logic             BZ,
   output logic             DN
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH);

   // The state names the phase whose NEXT enabled edge does the work:
   // S_SHIFT emits data bits, S_PAR emits the parity bit, S_DONE raises DN
   // and then drops it while returning to idle.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_PAR   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_sreg;
   logic [CW-1:0]    r_cnt;
   logic             r_par;
   logic             r_so;
   logic             r_sv;
   logic             r_bz;
   logic             r_dn;
   logic             r_rdy;

   logic             w_next_bit;
   logic [WIDTH-1:0] w_sreg_shifted;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_last_bit;
   state_t           w_after_data;

   // Bit order is fixed at elaboration: take from the top and shift left,
   // or take from the bottom and shift right.
   assign w_next_bit     = (MSB_FIRST != 0) ? r_sreg[WIDTH-1] : r_sreg[0];
   assign w_sreg_shifted = (MSB_FIRST != 0) ? {r_sreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, r_sreg[WIDTH-1:1]};
   assign w_cnt_inc      = r_cnt + 1'b1;
   assign w_last_bit     = (w_cnt_inc == LAST_CNT);
   assign w_after_data   = (PARITY_EN != 0) ? S_PAR : S_DONE;

   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         r_state <= S_IDLE;
         r_sreg  <= '0;
         r_cnt   <= '0;
         r_par   <= 1'b0;
         r_so    <= 1'b0;
         r_sv    <= 1'b0;
         r_bz    <= 1'b0;
         r_dn    <= 1'b0;
         r_rdy   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_sv <= 1'b0;
               r_dn <= 1'b0;
               if (V) begin
                  // Parity is taken from the captured word so later
                  // changes on A cannot affect the frame.
                  r_sreg  <= A;
                  r_par   <= ^A;
                  r_cnt   <= '0;
                  r_rdy   <= 1'b0;
                  r_bz    <= 1'b1;
                  r_state <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (E) begin
                  r_so   <= w_next_bit;
                  r_sv   <= 1'b1;
                  r_sreg <= w_sreg_shifted;
                  r_cnt  <= w_cnt_inc;
                  if (w_last_bit) begin
                     r_state <= w_after_data;
                  end
               end else begin
                  // Stall: SO keeps its last value, only SV drops.
                  r_sv <= 1'b0;
               end
            end

            S_PAR: begin
               if (E) begin
                  r_so    <= r_par;
                  r_sv    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_sv <= 1'b0;
               end
            end

            S_DONE: begin
               // First edge raises DN, second edge drops it and reopens
               // the handshake; E has no effect here.
               r_sv <= 1'b0;
               if (!r_dn) begin
                  r_dn <= 1'b1;
               end else begin
                  r_dn    <= 1'b0;
                  r_rdy   <= 1'b1;
                  r_bz    <= 1'b0;
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign RDY = r_rdy;
   assign SO  = r_so;
   assign SV  = r_sv;
   assign BZ  = r_bz;
   assign DN  = r_dn;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (MSB+parity and LSB/no-parity builds)

module tb_piso_serializer;

   logic       C = 1'b0;
   logic       R = 1'b0;
   logic [3:0] A = 4'd0;
   logic       V = 1'b0;
   logic       E = 1'b0;

   logic rdy0, so0, sv0, bz0, dn0;
   logic rdy1, so1, sv1, bz1, dn1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 C = ~C;

   // dut0: MSB first with parity; dut1: LSB first without parity.
   piso_serializer #(.WIDTH(4), .MSB_FIRST(1), .PARITY_EN(1)) u_dut0 (
      .C(C), .R(R), .A(A), .V(V), .RDY(rdy0), .E(E),
      .SO(so0), .SV(sv0), .BZ(bz0), .DN(dn0)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .PARITY_EN(0)) u_dut1 (
      .C(C), .R(R), .A(A), .V(V), .RDY(rdy1), .E(E),
      .SO(so1), .SV(sv1), .BZ(bz1), .DN(dn1)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a frame is a list of bits to emit (data in the
   // configured order, then parity), followed by one DN cycle and one
   // cycle to get back to ready.
   logic        e_so[2], e_sv[2], e_dn[2], e_rdy[2], e_bz[2];
   bit          m_busy[2], m_dn_done[2];
   int          m_left[2];
   logic [16:0] m_bits[2];

   task automatic model_reset(input int d);
      m_busy[d] = 0; m_dn_done[d] = 0; m_left[d] = 0; m_bits[d] = '0;
      e_so[d] = 0; e_sv[d] = 0; e_dn[d] = 0; e_rdy[d] = 1; e_bz[d] = 0;
   endtask

   task automatic build(input int d, input logic [3:0] a);
      logic [16:0] f;
      int n;
      f = '0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         int idx;
         idx = (d == 0) ? 3 - i : i;
         f = {f[15:0], a[idx]};
         n++;
      end
      if (d == 0) begin
         f = {f[15:0], ^a};
         n++;
      end
      m_bits[d] = f;
      m_left[d] = n;
   endtask

   task automatic model_step(input int d);
      if (!m_busy[d]) begin
         e_dn[d] = 0;
         e_sv[d] = 0;
         if (V) begin
            build(d, A);
            m_busy[d] = 1; m_dn_done[d] = 0; e_rdy[d] = 0; e_bz[d] = 1;
         end
      end else if (m_left[d] > 0) begin
         if (E) begin
            e_so[d] = m_bits[d][m_left[d]-1];
            e_sv[d] = 1;
            m_left[d]--;
         end else begin
            e_sv[d] = 0;
         end
      end else if (!m_dn_done[d]) begin
         e_dn[d] = 1; e_sv[d] = 0; m_dn_done[d] = 1;
      end else begin
         e_dn[d] = 0; m_busy[d] = 0; e_rdy[d] = 1; e_bz[d] = 0;
      end
   endtask

   initial begin
      model_reset(0);
      model_reset(1);
      forever begin
         @(posedge C or negedge R);
         for (int d = 0; d < 2; d++) begin
            if (!R) model_reset(d);
            else    model_step(d);
         end
      end
   end

   // Cycle-by-cycle scoreboard on the falling edge.
   initial begin
      forever begin
         @(negedge C);
         check("scoreboard dut0 {rdy,bz,dn,sv,so}", {11'b0, rdy0, bz0, dn0, sv0, so0},
               {11'b0, e_rdy[0], e_bz[0], e_dn[0], e_sv[0], e_so[0]});
         check("scoreboard dut1 {rdy,bz,dn,sv,so}", {11'b0, rdy1, bz1, dn1, sv1, so1},
               {11'b0, e_rdy[1], e_bz[1], e_dn[1], e_sv[1], e_so[1]});
      end
   end

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      tick();
      while (!(rdy0 && rdy1) && k < 40) begin
         tick();
         k++;
      end
      if (!(rdy0 && rdy1)) check("wait_idle timeout", 16'd0, 16'd1);
   endtask

   // Frame capture relative to the acceptance edge.
   logic [15:0] cb0, cb1;
   int cn0, cn1, dnc0, dnc1, rdc0, rdc1, cyc;

   task automatic collect_start();
      cb0 = '0; cb1 = '0; cn0 = 0; cn1 = 0;
      dnc0 = -1; dnc1 = -1; rdc0 = -1; rdc1 = -1; cyc = 0;
   endtask

   task automatic collect(input int n);
      repeat (n) begin
         tick();
         cyc++;
         if (sv0) begin cb0 = {cb0[14:0], so0}; cn0++; end
         if (sv1) begin cb1 = {cb1[14:0], so1}; cn1++; end
         if (dn0 && dnc0 < 0) dnc0 = cyc;
         if (dn1 && dnc1 < 0) dnc1 = cyc;
         if (rdy0 && rdc0 < 0 && dnc0 >= 0) rdc0 = cyc;
         if (rdy1 && rdc1 < 0 && dnc1 >= 0) rdc1 = cyc;
      end
   endtask

   task automatic accept(input logic [3:0] a);
      A = a; V = 1'b1; E = 1'b1;
      tick();
      V = 1'b0;
      A = 4'($urandom);
      collect_start();
   endtask

   typedef struct {
      logic [3:0] a;
      logic [4:0] exp0;  // MSB first + parity, first bit out at [4]
      logic [3:0] exp1;  // LSB first, first bit out at [3]
   } vec_t;

   vec_t vecs[6];

   initial begin
      vecs[0] = '{4'b1100, 5'b11000, 4'b0011};
      vecs[1] = '{4'b0011, 5'b00110, 4'b1100};
      vecs[2] = '{4'b0111, 5'b01111, 4'b1110};
      vecs[3] = '{4'b1010, 5'b10100, 4'b0101};
      vecs[4] = '{4'b1111, 5'b11110, 4'b1111};
      vecs[5] = '{4'b0000, 5'b00000, 4'b0000};

      // Reset held with V high: idle outputs, then acceptance at the first edge.
      R = 1'b0; V = 1'b1; A = 4'b1111; E = 1'b1;
      tick();
      tick();
      check("reset dut0 {rdy,bz,dn,sv,so}", {11'b0, rdy0, bz0, dn0, sv0, so0}, 16'b10000);
      check("reset dut1 {rdy,bz,dn,sv,so}", {11'b0, rdy1, bz1, dn1, sv1, so1}, 16'b10000);
      R = 1'b1;
      tick();
      check("accept after reset {rdy,bz}", {14'b0, rdy0, bz0}, 16'b01);
      V = 1'b0;

      // Table-driven frames with E held high.
      foreach (vecs[i]) begin
         wait_idle();
         accept(vecs[i].a);
         collect(8);
         check($sformatf("vec%0d dut0 bits", i), cb0, 16'(vecs[i].exp0));
         check($sformatf("vec%0d dut0 nbits", i), 16'(cn0), 16'd5);
         check($sformatf("vec%0d dut0 dn cycle", i), 16'(dnc0), 16'd6);
         check($sformatf("vec%0d dut0 rdy cycle", i), 16'(rdc0), 16'd7);
         check($sformatf("vec%0d dut1 bits", i), cb1, 16'(vecs[i].exp1));
         check($sformatf("vec%0d dut1 nbits", i), 16'(cn1), 16'd4);
         check($sformatf("vec%0d dut1 dn cycle", i), 16'(dnc1), 16'd5);
         check($sformatf("vec%0d dut1 rdy cycle", i), 16'(rdc1), 16'd6);
      end

      // Stall for 3 cycles after the second bit.
      wait_idle();
      accept(4'b1010);
      collect(2);
      E = 1'b0;
      repeat (3) begin
         collect(1);
         check("stall dut0 {sv,so}", {14'b0, sv0, so0}, 16'b00);
      end
      E = 1'b1;
      collect(6);
      check("stall dut0 bits", cb0, 16'b10100);
      check("stall dut0 dn cycle", 16'(dnc0), 16'd9);
      check("stall dut1 bits", cb1, 16'b0101);
      check("stall dut1 dn cycle", 16'(dnc1), 16'd8);

      // V while busy is ignored; the second word goes only once ready.
      wait_idle();
      accept(4'b1100);
      collect(2);
      A = 4'b0011; V = 1'b1;
      collect(1);
      V = 1'b0;
      collect(5);
      check("busy dut0 bits", cb0, 16'b11000);
      check("busy dut0 dn cycle", 16'(dnc0), 16'd6);
      check("busy dut1 bits", cb1, 16'b0011);
      check("busy dut0 idle after {rdy,bz}", {14'b0, rdy0, bz0}, 16'b10);
      accept(4'b0011);
      collect(8);
      check("second word dut0 bits", cb0, 16'b00110);

      // V held high: one ready cycle between frames.
      wait_idle();
      A = 4'b1001; V = 1'b1; E = 1'b1;
      tick();
      collect_start();
      collect(8);
      check("b2b dut0 bits", cb0, 16'b10010);
      check("b2b dut0 rdy cycle", 16'(rdc0), 16'd7);
      check("b2b dut0 reaccepted {rdy,bz}", {14'b0, rdy0, bz0}, 16'b01);
      V = 1'b0;

      // Asynchronous reset mid-frame after two bits.
      wait_idle();
      accept(4'b1100);
      collect(2);
      #2;
      R = 1'b0;
      #1;
      check("async reset dut0 {rdy,bz,dn,sv,so}", {11'b0, rdy0, bz0, dn0, sv0, so0}, 16'b10000);
      check("async reset dut1 {rdy,bz,dn,sv,so}", {11'b0, rdy1, bz1, dn1, sv1, so1}, 16'b10000);
      A = 4'b1111; V = 1'b1;
      @(posedge C);
      #2;
      R = 1'b1;
      tick();
      V = 1'b0;
      collect_start();
      collect(8);
      check("post-reset dut0 bits", cb0, 16'b11110);
      check("post-reset dut0 dn cycle", 16'(dnc0), 16'd6);

      // Randomized traffic against the scoreboard, with rare async resets.
      for (int i = 0; i < 600; i++) begin
         V = ($urandom_range(2) == 0);
         A = 4'($urandom);
         E = ($urandom_range(3) != 0);
         tick();
         if ($urandom_range(149) == 0) begin
            #1 R = 1'b0;
            #1 R = 1'b1;
         end
      end
      V = 1'b0;
      E = 1'b1;
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
